pong_game_ctrl: RTL
===================

Name: pong_game_ctrl

Overview:
Frame-rate game sequencer for the pong datapath. Once per frame (vblank rising edge) it samples ball and paddle positions, resolves wall/paddle/goal events, steers ball direction, keeps scores and runs serve/point/game-over sequencing. Sits beside vga_controller, ball and paddle in the pong top level, on the pixel clock; the ball block consumes its direction, run and recentre controls.

Parameters:
WIN_SCORE, 9, score that ends the game (scores are 4-bit, 1..15)
SERVE_FRAMES, 60, frames the ball is held centred before launch
MAX_SPEED, 15, speed ceiling (used only with SPEEDUP_EN)

Ports:
clk  in  1  pixel clock (clk_2 domain)
rst  in  1  synchronous, active-high reset
vblank  in  1  level from vga_controller; rising edge = frame tick
start  in  1  start/restart request, level, sampled on frame ticks
speed_in  in  4  base speed (switches)
ball_x  in  11  ball left edge, pixels
ball_y  in  11  ball top edge
lpad_y  in  11  left paddle top edge
rpad_y  in  11  right paddle top edge
ball_run  out  1  1 = ball moves this frame
ball_center  out  1  1-cycle pulse: ball reloads centre position
dir_x  out  1  0 = left, 1 = right
dir_y  out  1  0 = up, 1 = down
speed  out  4  ball step per frame
score_l  out  4  left player score
score_r  out  4  right player score
game_over  out  1  high in OVER state

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Frame tick: tick = vblank & ~vblank_d (vblank_d registered). All state changes below occur only on the cycle tick is high, except ball_center clearing.
- Reset values: state IDLE, ball_run 0, ball_center 0, dir_x 1, dir_y 1, speed speed_in-registered 0, scores 0, game_over 0, frame counter 0, vblank_d 0. Reset mid-operation aborts any state in the next cycle.
- States: IDLE, SERVE, PLAY, POINT, OVER (3-bit encoding in defs.v).
- IDLE: ball_run 0. On tick with start=1: scores<=0, ball_center pulse, counter<=0, ->SERVE.
- SERVE: ball_run 0; counter++ per tick; when counter==SERVE_FRAMES-1 on tick: ->PLAY, ball_run<=1.
- PLAY, per tick, evaluated in order, all using same sampled inputs:
  1. Wall: ball_y <= `TABLE_TOP -> dir_y<=1; ball_y+`BALL_SIZE >= `TABLE_BOTTOM -> dir_y<=0.
  2. Left paddle hit: dir_x==0, ball_x <= `TABLE_LEFT+`HMARGIN+`PADDLE_WIDTH, ball_x+`BALL_SIZE > `TABLE_LEFT+`HMARGIN, and y-overlap (ball_y+`BALL_SIZE > lpad_y and ball_y < lpad_y+`PADDLE_HEIGHT) -> dir_x<=1. Mirror for right paddle -> dir_x<=0.
  3. Goal: no paddle hit and ball_x <= `TABLE_LEFT -> score_r++; ball_x+`BALL_SIZE >= `TABLE_RIGHT -> score_l++. ball_run<=0, ->POINT. Serve goes toward scorer's opponent: dir_x<=scorer-left?0:1... i.e. dir_x points at the player who conceded.
- Wall and paddle events in same tick both apply (corner bounce). Paddle hit takes priority over goal in same tick.
- All comparisons 12-bit unsigned (zero-extend before add) so sums never wrap.
- POINT: if incremented score == WIN_SCORE -> OVER, game_over<=1. Else ball_center pulse, counter<=0, ->SERVE.
- Scores never exceed WIN_SCORE; no increment outside PLAY.
- OVER: ball_run 0, scores held. tick with start=1 -> same as IDLE start (scores cleared, game_over<=0, ->SERVE).
- ball_center: exactly one clk cycle wide.
- speed: registered speed_in each tick (without SPEEDUP_EN).

Optional Feature:
PONG_SPEEDUP_EN. Defined: speed reloads to speed_in at each serve launch; each paddle hit increments speed by 1, saturating at MAX_SPEED; speed_in changes mid-rally ignored. Undefined: speed = speed_in sampled every tick, no hit counting logic.

Decomposition:
- defs.v: state encodings, `TABLE_*, `HMARGIN, `PADDLE_WIDTH, `PADDLE_HEIGHT, `BALL_SIZE.
- Sub-module pong_collide: purely combinational hit/wall/goal flags from positions; FSM, scores, counters stay in pong_game_ctrl.

Test Plan:
- rst during PLAY with score_l=3 -> next cycle state IDLE, scores 0, ball_run 0, dir_x=1.
- IDLE, start=1 at tick -> ball_center 1-cycle pulse; ball_run rises exactly SERVE_FRAMES ticks later.
- PLAY, dir_x=0, ball_x at left paddle face, ball_y within lpad_y..lpad_y+`PADDLE_HEIGHT -> dir_x=1, no score change.
- PLAY, ball at top wall and right paddle same tick -> dir_y=1 and dir_x=0 together.
- ball_x<=`TABLE_LEFT, paddle missed, score_r=8, WIN_SCORE=9 -> score_r=9, game_over=1, ball_run 0; start then clears scores.
- PONG_SPEEDUP_EN, speed_in=14, three paddle hits -> speed 15,15,15 (saturates at MAX_SPEED).

Source files
------------

// File: rtl/pong_game_ctrl_pkg.sv
// Shared types and table geometry for the pong game sequencer.
// All geometry is 12-bit so position sums never wrap.
package pong_game_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StServe = 3'd1,
      StPlay  = 3'd2,
      StPoint = 3'd3,
      StOver  = 3'd4
   } state_e;

   localparam logic [11:0] TableLeft    = 12'd8;
   localparam logic [11:0] TableRight   = 12'd632;
   localparam logic [11:0] TableTop     = 12'd8;
   localparam logic [11:0] TableBottom  = 12'd472;
   localparam logic [11:0] Hmargin      = 12'd16;
   localparam logic [11:0] PaddleWidth  = 12'd8;
   localparam logic [11:0] PaddleHeight = 12'd64;
   localparam logic [11:0] BallSize     = 12'd8;

   function automatic logic [11:0] ext12(input logic [10:0] v);
      return {1'b0, v};
   endfunction

endpackage

// File: rtl/pong_game_ctrl_collide.sv
// Combinational wall, paddle and goal detection from sampled positions.
// Paddle hits only count when the ball travels toward that paddle.
module pong_collide
   import pong_game_ctrl_pkg::*;
(
   input  logic [10:0] ball_x,
   input  logic [10:0] ball_y,
   input  logic [10:0] lpad_y,
   input  logic [10:0] rpad_y,
   input  logic        dir_x,
   output logic        wall_top,
   output logic        wall_bot,
   output logic        hit_l,
   output logic        hit_r,
   output logic        goal_l,
   output logic        goal_r
);

   logic [11:0] bx, by, lp, rp;
   logic        ovl_l, ovl_r;

   assign bx = ext12(ball_x);
   assign by = ext12(ball_y);
   assign lp = ext12(lpad_y);
   assign rp = ext12(rpad_y);

   assign wall_top = (by <= TableTop);
   assign wall_bot = (by + BallSize >= TableBottom);

   assign ovl_l = (by + BallSize > lp) && (by < lp + PaddleHeight);
   assign ovl_r = (by + BallSize > rp) && (by < rp + PaddleHeight);

   assign hit_l = !dir_x && ovl_l &&
                  (bx <= TableLeft + Hmargin + PaddleWidth) &&
                  (bx + BallSize > TableLeft + Hmargin);
   assign hit_r = dir_x && ovl_r &&
                  (bx + BallSize >= TableRight - Hmargin - PaddleWidth) &&
                  (bx < TableRight - Hmargin);

   // goal_l: ball left the table on the left side, so the right player scores.
   assign goal_l = (bx <= TableLeft);
   assign goal_r = (bx + BallSize >= TableRight);

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-rate pong sequencer: serve/play/point/over FSM, scores, ball steering.
// Optional PONG_SPEEDUP_EN: speed reloads at launch and climbs on each paddle hit.
module pong_game_ctrl
   import pong_game_ctrl_pkg::*;
#(
   parameter int unsigned WIN_SCORE    = 9,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned MAX_SPEED    = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vblank,
   input  logic        start,
   input  logic [3:0]  speed_in,
   input  logic [10:0] ball_x,
   input  logic [10:0] ball_y,
   input  logic [10:0] lpad_y,
   input  logic [10:0] rpad_y,
   output logic        ball_run,
   output logic        ball_center,
   output logic        dir_x,
   output logic        dir_y,
   output logic [3:0]  speed,
   output logic [3:0]  score_l,
   output logic [3:0]  score_r,
   output logic        game_over
);

   state_e      state_q, state_d;
   logic        vblank_d_q;
   logic        run_q, run_d;
   logic        center_q, center_d;
   logic        dx_q, dx_d;
   logic        dy_q, dy_d;
   logic [3:0]  speed_q, speed_d;
   logic [3:0]  sl_q, sl_d;
   logic [3:0]  sr_q, sr_d;
   logic        over_q, over_d;
   logic [15:0] cnt_q, cnt_d;
   logic        tick;
   logic        wall_top, wall_bot, hit_l, hit_r, goal_l, goal_r;

   assign tick = vblank & ~vblank_d_q;

   pong_collide u_collide (
      .ball_x   (ball_x),
      .ball_y   (ball_y),
      .lpad_y   (lpad_y),
      .rpad_y   (rpad_y),
      .dir_x    (dx_q),
      .wall_top (wall_top),
      .wall_bot (wall_bot),
      .hit_l    (hit_l),
      .hit_r    (hit_r),
      .goal_l   (goal_l),
      .goal_r   (goal_r)
   );

`ifndef PONG_SPEEDUP_EN
   logic [3:0] unused_max_speed;
   assign unused_max_speed = 4'(MAX_SPEED);
`endif

   always_comb begin
      state_d  = state_q;
      run_d    = run_q;
      center_d = 1'b0;
      dx_d     = dx_q;
      dy_d     = dy_q;
      speed_d  = speed_q;
      sl_d     = sl_q;
      sr_d     = sr_q;
      over_d   = over_q;
      cnt_d    = cnt_q;

      if (tick) begin
`ifndef PONG_SPEEDUP_EN
         speed_d = speed_in;
`endif
         case (state_q)
            StIdle, StOver: begin
               run_d = 1'b0;
               if (start) begin
                  sl_d     = '0;
                  sr_d     = '0;
                  over_d   = 1'b0;
                  center_d = 1'b1;
                  cnt_d    = '0;
                  state_d  = StServe;
               end
            end
            StServe: begin
               if (cnt_q == 16'(SERVE_FRAMES - 1)) begin
                  run_d   = 1'b1;
                  state_d = StPlay;
`ifdef PONG_SPEEDUP_EN
                  speed_d = speed_in;
`endif
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            StPlay: begin
               if (wall_top) begin
                  dy_d = 1'b1;
               end else if (wall_bot) begin
                  dy_d = 1'b0;
               end
               // A paddle hit always wins over a goal seen in the same frame.
               if (hit_l || hit_r) begin
                  dx_d = hit_l;
`ifdef PONG_SPEEDUP_EN
                  if (speed_q < 4'(MAX_SPEED)) speed_d = speed_q + 4'd1;
`endif
               end else if (goal_l) begin
                  if (sr_q < 4'(WIN_SCORE)) sr_d = sr_q + 4'd1;
                  dx_d    = 1'b0;
                  run_d   = 1'b0;
                  state_d = StPoint;
               end else if (goal_r) begin
                  if (sl_q < 4'(WIN_SCORE)) sl_d = sl_q + 4'd1;
                  dx_d    = 1'b1;
                  run_d   = 1'b0;
                  state_d = StPoint;
               end
            end
            StPoint: begin
               if (sl_q == 4'(WIN_SCORE) || sr_q == 4'(WIN_SCORE)) begin
                  over_d  = 1'b1;
                  state_d = StOver;
               end else begin
                  center_d = 1'b1;
                  cnt_d    = '0;
                  state_d  = StServe;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         vblank_d_q <= 1'b0;
         run_q      <= 1'b0;
         center_q   <= 1'b0;
         dx_q       <= 1'b1;
         dy_q       <= 1'b1;
         speed_q    <= '0;
         sl_q       <= '0;
         sr_q       <= '0;
         over_q     <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         vblank_d_q <= vblank;
         run_q      <= run_d;
         center_q   <= center_d;
         dx_q       <= dx_d;
         dy_q       <= dy_d;
         speed_q    <= speed_d;
         sl_q       <= sl_d;
         sr_q       <= sr_d;
         over_q     <= over_d;
         cnt_q      <= cnt_d;
      end
   end

   assign ball_run    = run_q;
   assign ball_center = center_q;
   assign dir_x       = dx_q;
   assign dir_y       = dy_q;
   assign speed       = speed_q;
   assign score_l     = sl_q;
   assign score_r     = sr_q;
   assign game_over   = over_q;

endmodule
